// File: rtl/image_loader.sv
// Boot-time image loader: streams the instruction image (big-endian) and data image
// (little-endian) into byte-wide memories, then hands PC/$sp to the CPU and releases it.
module image_loader #(
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        word_i,
  input  logic               word_valid_i,
  output logic               word_ready_o,
  output logic               im_we_o,
  output logic [IMEM_AW-1:0] im_addr_o,
  output logic [7:0]         im_data_o,
  output logic               dm_we_o,
  output logic [DMEM_AW-1:0] dm_addr_o,
  output logic [7:0]         dm_data_o,
  output logic [31:0]        pc_init_o,
  output logic               pc_load_o,
  output logic [31:0]        sp_init_o,
  output logic               sp_load_o,
  output logic               cpu_run_o,
  output logic               err_o
);

  typedef enum logic [3:0] {
    I_PC, I_CNT, I_WORD, I_BYTE, D_SP, D_CNT, D_WORD, D_BYTE, DONE, ERR
  } state_e;

  localparam logic [34:0] IM_LIMIT = 35'(1) << IMEM_AW;
  localparam logic [34:0] DM_LIMIT = 35'(1) << DMEM_AW;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, sp_q, sp_d, cnt_q, cnt_d, k_q, k_d, word_q, word_d;
  logic [1:0]  b_q, b_d;
  logic        pc_load_q, pc_load_d, sp_load_q, sp_load_d;
  logic        run_q, run_d, err_q, err_d;
  logic        xfer;
  logic [34:0] im_end, dm_end;
  logic [31:0] k_inc;

  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [7:0] le_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign word_ready_o = !rst_i && (state_q inside {I_PC, I_CNT, I_WORD, D_SP, D_CNT, D_WORD});
  assign xfer         = word_valid_i && word_ready_o;
  // Widened so the end-of-image address can never wrap for any 32-bit count.
  assign im_end       = {3'b000, pc_q} + {1'b0, word_i, 2'b00};
  assign dm_end       = {1'b0, word_i, 2'b00};
  assign k_inc        = k_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    b_d       = b_q;
    word_d    = word_q;
    pc_load_d = 1'b0;
    sp_load_d = 1'b0;
    case (state_q)
      I_PC: if (xfer) begin
        pc_d      = word_i;
        pc_load_d = 1'b1;
        state_d   = I_CNT;
      end
      I_CNT: if (xfer) begin
        cnt_d = word_i;
        k_d   = 32'd0;
        if (word_i == 32'd0)        state_d = D_SP;
        else if (im_end > IM_LIMIT) state_d = ERR;
        else                        state_d = I_WORD;
      end
      I_WORD: if (xfer) begin
        word_d  = word_i;
        b_d     = 2'd0;
        state_d = I_BYTE;
      end
      I_BYTE: begin
        b_d = b_q + 2'd1;
        if (b_q == 2'd3) begin
          k_d     = k_inc;
          state_d = (k_inc == cnt_q) ? D_SP : I_WORD;
        end
      end
      D_SP: if (xfer) begin
        sp_d      = word_i;
        sp_load_d = 1'b1;
        state_d   = D_CNT;
      end
      D_CNT: if (xfer) begin
        cnt_d = word_i;
        k_d   = 32'd0;
        if (word_i == 32'd0)        state_d = DONE;
        else if (dm_end > DM_LIMIT) state_d = ERR;
        else                        state_d = D_WORD;
      end
      D_WORD: if (xfer) begin
        word_d  = word_i;
        b_d     = 2'd0;
        state_d = D_BYTE;
      end
      D_BYTE: begin
        b_d = b_q + 2'd1;
        if (b_q == 2'd3) begin
          k_d     = k_inc;
          state_d = (k_inc == cnt_q) ? DONE : D_WORD;
        end
      end
      default: state_d = state_q;
    endcase
    run_d = (state_d == DONE);
    err_d = (state_d == ERR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= I_PC;
      pc_q      <= '0;
      sp_q      <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      b_q       <= '0;
      word_q    <= '0;
      pc_load_q <= 1'b0;
      sp_load_q <= 1'b0;
      run_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      b_q       <= b_d;
      word_q    <= word_d;
      pc_load_q <= pc_load_d;
      sp_load_q <= sp_load_d;
      run_q     <= run_d;
      err_q     <= err_d;
    end
  end

  assign im_we_o   = (state_q == I_BYTE);
  assign im_addr_o = im_we_o ? (pc_q[IMEM_AW-1:0] + {k_q[IMEM_AW-3:0], 2'b00} + IMEM_AW'(b_q)) : '0;
  assign im_data_o = im_we_o ? be_byte(word_q, b_q) : 8'd0;
  assign dm_we_o   = (state_q == D_BYTE);
  assign dm_addr_o = dm_we_o ? ({k_q[DMEM_AW-3:0], 2'b00} + DMEM_AW'(b_q)) : '0;
  assign dm_data_o = dm_we_o ? le_byte(word_q, b_q) : 8'd0;
  assign pc_init_o = pc_q;
  assign pc_load_o = pc_load_q;
  assign sp_init_o = sp_q;
  assign sp_load_o = sp_load_q;
  assign cpu_run_o = run_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: the driver queues expected writes/loads as it
// issues words; a negedge monitor pops and compares every strobe the DUT raises.
module tb_image_loader;

  logic        clk;
  logic        rst_i;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        im_we_o;
  logic [9:0]  im_addr_o;
  logic [7:0]  im_data_o;
  logic        dm_we_o;
  logic [9:0]  dm_addr_o;
  logic [7:0]  dm_data_o;
  logic [31:0] pc_init_o;
  logic        pc_load_o;
  logic [31:0] sp_init_o;
  logic        sp_load_o;
  logic        cpu_run_o;
  logic        err_o;

  image_loader #(.IMEM_AW(10), .DMEM_AW(10)) dut (
    .clk_i(clk), .rst_i(rst_i), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
    .im_data_o(im_data_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_data_o(dm_data_o), .pc_init_o(pc_init_o), .pc_load_o(pc_load_o),
    .sp_init_o(sp_init_o), .sp_load_o(sp_load_o), .cpu_run_o(cpu_run_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t         exp_im[$];
  wr_t         exp_dm[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_sp[$];
  wr_t         e_im, e_dm;

  logic [7:0]  im_mem [0:1023];
  logic [7:0]  dm_mem [0:1023];
  logic [31:0] img_i [0:3];
  logic [31:0] img_d [0:3];

  localparam logic [7:0] IM_EXP [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] DM_EXP [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int c0, c1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we_o && dm_we_o) chk("we_exclusive", 64'(dm_we_o), 64'd0);
    if (cpu_run_o && err_o) chk("run_err_exclusive", 64'(err_o), 64'd0);
    if (im_we_o) begin
      chk("ready_in_ibyte", 64'(word_ready_o), 64'd0);
      if (exp_im.size() == 0) chk("im_we_unexpected", 64'(im_we_o), 64'd0);
      else begin
        e_im = exp_im.pop_front();
        chk("im_addr", 64'(im_addr_o), 64'(e_im.a));
        chk("im_data", 64'(im_data_o), 64'(e_im.d));
      end
      im_mem[im_addr_o] = im_data_o;
    end
    if (dm_we_o) begin
      chk("ready_in_dbyte", 64'(word_ready_o), 64'd0);
      if (exp_dm.size() == 0) chk("dm_we_unexpected", 64'(dm_we_o), 64'd0);
      else begin
        e_dm = exp_dm.pop_front();
        chk("dm_addr", 64'(dm_addr_o), 64'(e_dm.a));
        chk("dm_data", 64'(dm_data_o), 64'(e_dm.d));
      end
      dm_mem[dm_addr_o] = dm_data_o;
    end
    if (pc_load_o) begin
      if (exp_pc.size() == 0) chk("pc_load_unexpected", 64'(pc_load_o), 64'd0);
      else chk("pc_init", 64'(pc_init_o), 64'(exp_pc.pop_front()));
    end
    if (sp_load_o) begin
      if (exp_sp.size() == 0) chk("sp_load_unexpected", 64'(sp_load_o), 64'd0);
      else chk("sp_init", 64'(sp_init_o), 64'(exp_sp.pop_front()));
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      im_mem[i] = 8'hEE;
      dm_mem[i] = 8'hEE;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    word_valid_i = 1'b0;
    @(negedge clk);
    chk("ready_during_reset", 64'(word_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_im.delete();
    exp_dm.delete();
    exp_pc.delete();
    exp_sp.delete();
    @(negedge clk);
    chk("reset_pc_sp", {pc_init_o, sp_init_o}, 64'd0);
    chk("reset_strobes", {im_we_o, im_addr_o, im_data_o, dm_we_o, dm_addr_o, dm_data_o,
                          pc_load_o, sp_load_o, cpu_run_o, err_o}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; optional idle cycles afterwards.
  task automatic send(input logic [31:0] w, input int gap);
    bit got;
    got = 1'b0;
    word_i = w;
    word_valid_i = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (word_ready_o) begin
        got = 1'b1;
        last_acc = cyc;
      end
    end
    if (!got) chk("send_timeout", 64'(word_ready_o), 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
    if (gap > 0) begin
      word_valid_i = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic load(input logic [31:0] pc, input int n, input logic [31:0] sp,
                      input int m, input int gap, output int c_first);
    exp_pc.push_back(pc);
    send(pc, gap);
    c_first = last_acc;
    send(32'(n), gap);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++)
        exp_im.push_back('{a: 10'(pc + 32'(4 * k + b)), d: img_i[k][31 - 8 * b -: 8]});
      send(img_i[k], gap);
    end
    exp_sp.push_back(sp);
    send(sp, gap);
    send(32'(m), gap);
    for (int k = 0; k < m; k++) begin
      for (int b = 0; b < 4; b++)
        exp_dm.push_back('{a: 10'(4 * k + b), d: img_d[k][8 * b +: 8]});
      send(img_d[k], gap);
    end
    word_valid_i = 1'b0;
  endtask

  task automatic wait_run(output int c);
    bit seen;
    seen = 1'b0;
    c = -1;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (cpu_run_o) begin
        seen = 1'b1;
        c = cyc;
      end
    end
    if (!seen) chk("run_timeout", 64'(cpu_run_o), 64'd1);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) chk({tag, "_im_byte"}, 64'(im_mem[10'h10 + i]), 64'(IM_EXP[i]));
    for (int i = 0; i < 4; i++) chk({tag, "_dm_byte"}, 64'(dm_mem[i]), 64'(DM_EXP[i]));
    chk({tag, "_im_below"}, 64'(im_mem[10'h0F]), 64'hEE);
    chk({tag, "_im_above"}, 64'(im_mem[10'h18]), 64'hEE);
    chk({tag, "_dm_above"}, 64'(dm_mem[4]), 64'hEE);
  endtask

  initial begin
    rst_i = 1'b1;
    word_i = '0;
    word_valid_i = 1'b0;
    img_i[0] = 32'h2008_0005;
    img_i[1] = 32'hFC00_0000;
    img_i[2] = '0;
    img_i[3] = '0;
    img_d[0] = 32'h1122_3344;
    img_d[1] = '0;
    img_d[2] = '0;
    img_d[3] = '0;
    do_reset();

    // Nominal load, words back to back: 4 header cycles + 5 cycles per image word.
    clear_mem();
    load(32'h0000_0010, 2, 32'h0000_0400, 1, 0, c0);
    wait_run(c1);
    chk("nominal_run_latency", 64'(c1 - c0), 64'd19);
    chk("nominal_err", 64'(err_o), 64'd0);
    chk("nominal_pc_hold", 64'(pc_init_o), 64'h10);
    chk("nominal_sp_hold", 64'(sp_init_o), 64'h400);
    check_mem("nominal");

    // Words offered after DONE are ignored.
    word_i = 32'hDEAD_BEEF;
    word_valid_i = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("done_ready", 64'(word_ready_o), 64'd0);
      chk("done_run", 64'(cpu_run_o), 64'd1);
    end
    word_valid_i = 1'b0;

    // Same image with an idle cycle after each accepted word.
    do_reset();
    clear_mem();
    load(32'h0000_0010, 2, 32'h0000_0400, 1, 1, c0);
    wait_run(c1);
    check_mem("gaps");

    // Empty images: run after the four header transfers, no memory strobes.
    do_reset();
    load(32'h0000_0020, 0, 32'h0000_0300, 0, 0, c0);
    wait_run(c1);
    chk("zero_run_latency", 64'(c1 - c0), 64'd4);
    chk("zero_pc", 64'(pc_init_o), 64'h20);
    chk("zero_sp", 64'(sp_init_o), 64'h300);

    // Instruction image runs past the top of IMEM: 0x3FC + 8 > 0x400.
    do_reset();
    exp_pc.push_back(32'h0000_03FC);
    send(32'h0000_03FC, 0);
    send(32'd2, 0);
    word_i = 32'hCAFE_F00D;
    repeat (6) begin
      @(negedge clk);
      chk("ovf_err", 64'(err_o), 64'd1);
      chk("ovf_run", 64'(cpu_run_o), 64'd0);
      chk("ovf_ready", 64'(word_ready_o), 64'd0);
    end
    word_valid_i = 1'b0;

    // Reset lands on the second byte write of instruction word 0, then a full reload.
    do_reset();
    clear_mem();
    exp_pc.push_back(32'h0000_0010);
    send(32'h0000_0010, 0);
    send(32'd2, 0);
    for (int b = 0; b < 4; b++)
      exp_im.push_back('{a: 10'(32'h10 + 32'(b)), d: img_i[0][31 - 8 * b -: 8]});
    send(img_i[0], 0);
    @(posedge clk);
    #1;
    do_reset();
    clear_mem();
    load(32'h0000_0010, 2, 32'h0000_0400, 1, 0, c0);
    wait_run(c1);
    chk("reload_run_latency", 64'(c1 - c0), 64'd19);
    check_mem("reload");

    repeat (4) @(negedge clk);
    chk("pending_im", 64'(exp_im.size()), 64'd0);
    chk("pending_dm", 64'(exp_dm.size()), 64'd0);
    chk("pending_pc", 64'(exp_pc.size()), 64'd0);
    chk("pending_sp", 64'(exp_sp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
